spi_reg_ctrl: RTL
=================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, giving the register count (legal range 1..64).
REQ-002 SHALL have parameter DEVICE_ID, default 8'hD1, giving the byte returned during a command byte.
REQ-003 SHALL have port i_Clk, input, 1 bit: the single clock, shared with the SPI slave's system clock.
REQ-004 SHALL have port i_Rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port i_RX_DV, input, 1 bit: one-cycle pulse from the SPI slave meaning i_RX_Byte is valid.
REQ-006 SHALL have port i_RX_Byte, input, 8 bits: byte received on MOSI.
REQ-007 SHALL have port i_SPI_CS_n, input, 1 bit: raw chip select, asynchronous to i_Clk.
REQ-008 SHALL have port o_TX_DV, output, 1 bit: one-cycle pulse that loads o_TX_Byte into the SPI slave.
REQ-009 SHALL have port o_TX_Byte, output, 8 bits: next byte to shift out on MISO.
REQ-010 SHALL have port o_Regs, output, 8*NUM_REGS bits: flat register image, with reg k at bits [8k+7:8k].
REQ-011 SHALL have port o_Wr_Strobe, output, 1 bit: one-cycle pulse for each committed register write.
REQ-012 SHALL have port o_Wr_Addr, output, 6 bits: address of the committed write.
REQ-013 SHALL have port o_Addr_Err, output, 1 bit: sticky out-of-range access flag.
REQ-014 SHALL have port o_Busy, output, 1 bit: high while the FSM is not in IDLE.

Function
REQ-015 SHALL synchronise i_SPI_CS_n with 2 flops (reset value 1) and detect its rising edge as end-of-frame (EOF).
REQ-016 SHALL decode the command byte as: bit7 R/W (1 = read), bit6 AUTO_INC, bits[5:0] ADDR.
REQ-017 SHALL implement FSM states IDLE, WRITE, READ; the reset state is IDLE.
REQ-018 In IDLE, an i_RX_DV SHALL latch the command; the FSM then goes to WRITE if bit7=0, else READ.
REQ-019 On entry to READ, SHALL pulse o_TX_DV exactly 1 cycle after the command i_RX_DV, with o_TX_Byte = reg[ADDR].
REQ-020 In READ, each i_RX_DV (dummy byte) SHALL advance the address if AUTO_INC, then pulse o_TX_DV 1 cycle later with the data at the new address.
REQ-021 In READ, if AUTO_INC=0 the address SHALL stay fixed, so the same register is returned repeatedly.
REQ-022 In WRITE, each i_RX_DV SHALL write i_RX_Byte to reg[addr] on the next edge, pulse o_Wr_Strobe with o_Wr_Addr=addr, and increment addr if AUTO_INC.
REQ-023 Address increment SHALL wrap modulo NUM_REGS (NUM_REGS-1 -> 0).
REQ-024 A write with addr >= NUM_REGS SHALL be discarded, with no o_Wr_Strobe, and SHALL set o_Addr_Err.
REQ-025 A read with addr >= NUM_REGS SHALL return 8'h00 and SHALL set o_Addr_Err.
REQ-026 o_Addr_Err SHALL clear only on reset or on a write to the last register (addr NUM_REGS-1) with data bit7=1.
REQ-027 On EOF, the FSM SHALL return to IDLE and pulse o_TX_DV with o_TX_Byte=DEVICE_ID, so the next frame's command byte returns the ID.
REQ-028 If EOF and i_RX_DV occur in the same cycle, the byte SHALL be processed first (write committed) and the next state SHALL be IDLE.
REQ-029 If i_RX_DV arrives in IDLE while CS is synchronously high, it SHALL be ignored.
REQ-030 o_Busy SHALL be 1 exactly when state != IDLE.
REQ-031 o_TX_DV SHALL never assert on two consecutive cycles; the minimum i_RX_DV spacing is 16 cycles.

Reset
REQ-032 i_Rst high SHALL asynchronously force: state IDLE, all regs 8'h00, o_TX_DV 0, o_TX_Byte 8'h00, o_Wr_Strobe 0, o_Wr_Addr 0, o_Addr_Err 0, o_Busy 0, and CS sync flops 1.
REQ-033 On the first cycle after reset release, SHALL pulse o_TX_DV with o_TX_Byte=DEVICE_ID.
REQ-034 Reset asserted mid-frame SHALL abort the frame; after release, the next i_RX_DV with CS low SHALL be treated as a command.

Verification
REQ-035 Release reset -> a single o_TX_DV pulse with o_TX_Byte=8'hD1; o_Regs all zero.
REQ-036 CS low; bytes 8'h43, 8'h11, 8'h22 (write, AUTO_INC, addr 3); CS high -> reg3=8'h11, reg4=8'h22, two o_Wr_Strobe pulses with addr 3 then 4, FSM back in IDLE.
REQ-037 Preload reg15=8'hAA, reg0=8'hBB; frame with 8'hCF, then two dummy bytes -> o_TX_Byte sequence 8'hAA, then 8'hBB (wrap), then reg1.
REQ-038 Frame with 8'h3F, then 8'h55 (write to addr 63, NUM_REGS=16) -> no strobe, o_Regs unchanged, o_Addr_Err=1; later write 8'h80 to addr 15 -> o_Addr_Err=0.
REQ-039 EOF coincident with the i_RX_DV of a write data byte -> write committed, state IDLE, o_TX_Byte=8'hD1.
REQ-040 Assert i_Rst during a READ frame -> all outputs at reset values immediately; the next frame's first byte is decoded as a command.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// Register file behind an SPI slave byte interface: command byte (R/W, AUTO_INC, ADDR)
// followed by data bytes. Frames end on the synchronised rising edge of chip select.
module spi_reg_ctrl #(
  parameter int          NUM_REGS  = 16,
  parameter logic [7:0]  DEVICE_ID = 8'hD1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_RX_DV,
  input  logic [7:0]              i_RX_Byte,
  input  logic                    i_SPI_CS_n,
  output logic                    o_TX_DV,
  output logic [7:0]              o_TX_Byte,
  output logic [8*NUM_REGS-1:0]   o_Regs,
  output logic                    o_Wr_Strobe,
  output logic [5:0]              o_Wr_Addr,
  output logic                    o_Addr_Err,
  output logic                    o_Busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam logic [6:0] NREGS_W   = 7'(NUM_REGS);
  localparam logic [5:0] LAST_ADDR = 6'(NUM_REGS - 1);

  state_t      state_q, state_d;
  logic [5:0]  addr_q, addr_d;
  logic        auto_q, auto_d;
  logic        tx_dv_q, tx_dv_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [5:0]  wr_addr_q, wr_addr_d;
  logic        err_q, err_d;
  logic        boot_q;
  logic        cs_meta_q, cs_sync_q, cs_last_q;
  logic [7:0]  regs_q [NUM_REGS];

  logic        eof;
  logic        wr_en;
  logic [5:0]  addr_inc;
  logic [5:0]  rd_addr;
  logic        rd_ok;
  logic        wr_ok;
  logic [7:0]  rd_data;

  assign eof   = cs_sync_q & ~cs_last_q;
  assign wr_ok = ({1'b0, addr_q} < NREGS_W);

  // Chip-select synchroniser and edge history; all idle high so reset never fakes an EOF.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cs_meta_q <= 1'b1;
      cs_sync_q <= 1'b1;
      cs_last_q <= 1'b1;
    end else begin
      cs_meta_q <= i_SPI_CS_n;
      cs_sync_q <= cs_meta_q;
      cs_last_q <= cs_sync_q;
    end
  end

  // Address a read will use: the command's ADDR in IDLE, else the (possibly advanced) frame address.
  always_comb begin
    addr_inc = (addr_q >= LAST_ADDR) ? 6'd0 : (addr_q + 6'd1);
    if (state_q == ST_READ) begin
      rd_addr = auto_q ? addr_inc : addr_q;
    end else begin
      rd_addr = i_RX_Byte[5:0];
    end
    rd_ok = ({1'b0, rd_addr} < NREGS_W);
  end

  // Read mux; out-of-range addresses match no entry and return zero.
  always_comb begin
    rd_data = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == 6'(k)) begin
        rd_data = regs_q[k];
      end else begin
        rd_data = rd_data;
      end
    end
  end

  // Next-state and output decode; EOF is applied last so a coincident byte is still processed.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    auto_d      = auto_q;
    tx_dv_d     = 1'b0;
    tx_byte_d   = tx_byte_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    err_d       = err_q;
    wr_en       = 1'b0;

    if (boot_q) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = DEVICE_ID;
    end else begin
      tx_dv_d   = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_RX_DV && !cs_sync_q) begin
          addr_d = i_RX_Byte[5:0];
          auto_d = i_RX_Byte[6];
          if (i_RX_Byte[7]) begin
            state_d   = ST_READ;
            tx_dv_d   = 1'b1;
            tx_byte_d = rd_data;
            err_d     = err_q | ~rd_ok;
          end else begin
            state_d   = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (i_RX_DV) begin
          addr_d    = rd_addr;
          tx_dv_d   = 1'b1;
          tx_byte_d = rd_data;
          err_d     = err_q | ~rd_ok;
        end else begin
          addr_d    = addr_q;
        end
      end
      ST_WRITE: begin
        if (i_RX_DV) begin
          if (wr_ok) begin
            wr_en       = 1'b1;
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            if ((addr_q == LAST_ADDR) && i_RX_Byte[7]) begin
              err_d = 1'b0;
            end else begin
              err_d = err_q;
            end
          end else begin
            err_d = 1'b1;
          end
          addr_d = auto_q ? addr_inc : addr_q;
        end else begin
          addr_d = addr_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (eof) begin
      state_d   = ST_IDLE;
      tx_dv_d   = 1'b1;
      tx_byte_d = DEVICE_ID;
    end else begin
      state_d   = state_d;
    end
  end

  // Control and output registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= 6'd0;
      auto_q      <= 1'b0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= 8'h00;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 6'd0;
      err_q       <= 1'b0;
      boot_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      auto_q      <= auto_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      err_q       <= err_d;
      boot_q      <= 1'b0;
    end
  end

  // Register file.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_en && (addr_q == 6'(k))) begin
          regs_q[k] <= i_RX_Byte;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_Regs[8*g +: 8] = regs_q[g];
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Wr_Strobe = wr_strobe_q;
  assign o_Wr_Addr   = wr_addr_q;
  assign o_Addr_Err  = err_q;
  assign o_Busy      = (state_q != ST_IDLE);

endmodule
